// File: rtl/bus_arbiter_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb_pkg
// Brief    : Shared types and defaults for the round-robin bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

  localparam int OWNER_W             = 3;
  localparam int BEGIN_TIMEOUT_DEF   = 16;
  localparam int MAX_XFER_CYCLES_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANT      = 2'd1,
    ST_WAIT_BEGIN = 2'd2,
    ST_WAIT_END   = 2'd3
  } arb_state_t;

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/bus_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr_if
// Brief    : Request/grant and shared-bus tracking signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_rr_if
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4
);

  logic [NUM_MASTERS-1:0] request_in;
  logic [NUM_MASTERS-1:0] grant_out;
  logic                   begin_transaction_in;
  logic                   end_transaction_in;
  logic                   bus_error_in;
  logic [OWNER_W-1:0]     owner_idx;
  logic                   owner_valid;
  logic                   begin_timeout;
  logic                   bus_timeout;
  logic [1:0]             arb_state;

  // slave: the arbiter itself; master: the requesters and shared-bus side
  modport slave (
    input  request_in, begin_transaction_in, end_transaction_in, bus_error_in,
    output grant_out, owner_idx, owner_valid, begin_timeout, bus_timeout, arb_state
  );

  modport master (
    output request_in, begin_transaction_in, end_transaction_in, bus_error_in,
    input  grant_out, owner_idx, owner_valid, begin_timeout, bus_timeout, arb_state
  );

endinterface : bus_arbiter_rr_if
`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Combinational round-robin search starting after the last winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) (
  input  wire logic [NUM_MASTERS-1:0] i_request,
  input  wire logic [OWNER_W-1:0]     i_last_grant,
  output logic      [OWNER_W-1:0]     o_winner,
  output logic                        o_found
);

  logic [OWNER_W-1:0] w_dist;
  logic [OWNER_W-1:0] w_best_dist;

  // The requester closest (mod NUM_MASTERS) after the last grant wins.
  always_comb begin
    o_winner    = '0;
    o_found     = 1'b0;
    w_dist      = '0;
    w_best_dist = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_dist = OWNER_W'((i + NUM_MASTERS - int'(i_last_grant) - 1) % NUM_MASTERS);
      if (i_request[i] && (!o_found || (w_dist < w_best_dist))) begin
        o_found     = 1'b1;
        o_winner    = OWNER_W'(i);
        w_best_dist = w_dist;
      end
    end
  end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr
// Brief    : Round-robin owner arbitration for a shared bus with transaction
//            tracking. Optional macro BUS_ARB_TIMEOUT_EN adds a WAIT_END
//            watchdog driving bus_timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int BEGIN_TIMEOUT   = BEGIN_TIMEOUT_DEF,
  parameter int MAX_XFER_CYCLES = MAX_XFER_CYCLES_DEF
) (
  input  wire logic       clock,
  input  wire logic       n_reset,
  bus_arbiter_rr_if.slave bus
);

  localparam int c_begin_cnt_w = $clog2(BEGIN_TIMEOUT) + 1;
  localparam logic [c_begin_cnt_w-1:0] c_begin_last = c_begin_cnt_w'(BEGIN_TIMEOUT - 1);
  localparam logic [OWNER_W-1:0] c_last_reset = OWNER_W'(NUM_MASTERS - 1);

  if ((NUM_MASTERS < 2) || (NUM_MASTERS > 8) || (BEGIN_TIMEOUT < 2) ||
      (MAX_XFER_CYCLES < 2)) begin : g_param_check
    $error("bus_arbiter_rr: parameter out of range");
  end

  arb_state_t                r_state;
  arb_state_t                w_state_nxt;
  logic [OWNER_W-1:0]        r_owner_idx;
  logic [OWNER_W-1:0]        r_last_grant;
  logic [OWNER_W-1:0]        w_winner;
  logic                      w_found;
  logic [c_begin_cnt_w-1:0]  r_begin_cnt;
  logic                      w_begin_timeout;
  logic                      w_bus_timeout;
  logic                      w_xfer_expired;

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .i_request    (bus.request_in),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_found      (w_found)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int c_xfer_cnt_w = $clog2(MAX_XFER_CYCLES) + 1;
  localparam logic [c_xfer_cnt_w-1:0] c_xfer_last = c_xfer_cnt_w'(MAX_XFER_CYCLES - 1);

  logic [c_xfer_cnt_w-1:0] r_xfer_cnt;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_xfer_cnt <= '0;
    end else if (r_state != ST_WAIT_END) begin
      r_xfer_cnt <= '0;
    end else if (r_xfer_cnt != '1) begin
      r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  assign w_xfer_expired = (r_state == ST_WAIT_END) && (r_xfer_cnt == c_xfer_last);
`else
  assign w_xfer_expired = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Owner is only re-latched on a new win so the bus mux select stays stable in IDLE.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_owner_idx  <= '0;
      r_last_grant <= c_last_reset;
      r_begin_cnt  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_found) begin
        r_owner_idx  <= w_winner;
        r_last_grant <= w_winner;
      end
      if (r_state != ST_WAIT_BEGIN) begin
        r_begin_cnt <= '0;
      end else if (r_begin_cnt != '1) begin
        r_begin_cnt <= r_begin_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_begin_timeout = 1'b0;
    w_bus_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_state_nxt = ST_WAIT_BEGIN;
      end
      ST_WAIT_BEGIN: begin
        // A lone end_transaction_in here belongs to nobody and is ignored.
        if (bus.begin_transaction_in) begin
          w_state_nxt = bus.end_transaction_in ? ST_IDLE : ST_WAIT_END;
        end else if (r_begin_cnt == c_begin_last) begin
          w_begin_timeout = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      ST_WAIT_END: begin
        if (bus.end_transaction_in) begin
          w_state_nxt = ST_IDLE;
        end else if (w_xfer_expired) begin
          w_bus_timeout = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.grant_out     = (r_state == ST_GRANT) ? (NUM_MASTERS'(1) << r_owner_idx) : '0;
  assign bus.owner_idx     = r_owner_idx;
  assign bus.owner_valid   = (r_state != ST_IDLE);
  assign bus.begin_timeout = w_begin_timeout;
  assign bus.bus_timeout   = w_bus_timeout;
  assign bus.arb_state     = r_state;

endmodule : bus_arbiter_rr
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_rr
// Brief    : Directed self-checking bench for bus_arbiter_rr (4 masters);
//            the watchdog step follows BUS_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;
  import bus_arb_pkg::*;

  localparam int NM = 4;

  logic clock = 1'b0;
  logic n_reset;
  int   total = 0;
  int   bad   = 0;

  bus_arbiter_rr_if #(.NUM_MASTERS(NM)) bus ();

  bus_arbiter_rr #(
    .NUM_MASTERS     (NM),
    .BEGIN_TIMEOUT   (16),
    .MAX_XFER_CYCLES (1024)
  ) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then let outputs settle.
  task automatic step(input logic rn, input logic [NM-1:0] req,
                      input logic b, input logic e, input logic err);
    @(negedge clock);
    n_reset                  = rn;
    bus.request_in           = req;
    bus.begin_transaction_in = b;
    bus.end_transaction_in   = e;
    bus.bus_error_in         = err;
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    n_reset                  = 1'b0;
    bus.request_in           = '0;
    bus.begin_transaction_in = 1'b0;
    bus.end_transaction_in   = 1'b0;
    bus.bus_error_in         = 1'b0;

    // Reset state
    step(0, 4'b0000, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 0);
    chk("rst_grant", bus.grant_out, 4'b0000);
    chk("rst_owner_idx", bus.owner_idx, 0);
    chk("rst_owner_valid", bus.owner_valid, 0);
    chk("rst_state", bus.arb_state, 0);
    chk("rst_begin_timeout", bus.begin_timeout, 0);
    chk("rst_bus_timeout", bus.bus_timeout, 0);

    // 1: single request, one-cycle grant, begin/end tracking
    step(1, 4'b0100, 0, 0, 0);
    chk("t1_idle_grant", bus.grant_out, 4'b0000);
    chk("t1_idle_valid", bus.owner_valid, 0);
    step(1, 4'b0100, 0, 0, 0);
    chk("t1_grant", bus.grant_out, 4'b0100);
    chk("t1_owner_idx", bus.owner_idx, 2);
    chk("t1_valid", bus.owner_valid, 1);
    chk("t1_state_grant", bus.arb_state, 1);
    step(1, 4'b0000, 0, 0, 0);
    chk("t1_grant_once", bus.grant_out, 4'b0000);
    chk("t1_state_wb", bus.arb_state, 2);
    step(1, 4'b0000, 1, 0, 0);
    chk("t1_state_wb_begin", bus.arb_state, 2);
    step(1, 4'b0000, 0, 0, 0);
    chk("t1_state_we", bus.arb_state, 3);
    repeat (3) step(1, 4'b0000, 0, 0, 0);
    step(1, 4'b0000, 0, 1, 0);
    chk("t1_valid_at_end", bus.owner_valid, 1);
    chk("t1_state_at_end", bus.arb_state, 3);
    step(1, 4'b0000, 0, 0, 0);
    chk("t1_released", bus.owner_valid, 0);
    chk("t1_state_idle", bus.arb_state, 0);
    chk("t1_owner_held", bus.owner_idx, 2);

    // 2: all masters requesting, rotation 0,1,2,3,0 with 3-cycle transactions
    step(0, 4'b1111, 0, 0, 0);
    step(1, 4'b1111, 0, 0, 0);
    chk("t2_idle_after_reset", bus.arb_state, 0);
    for (int k = 0; k < 5; k++) begin
      logic [NM-1:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      step(1, 4'b1111, 0, 0, 0);
      chk("t2_grant", bus.grant_out, exp_g);
      chk("t2_owner_idx", bus.owner_idx, k % 4);
      step(1, 4'b1111, 1, 0, 0);
      step(1, 4'b1111, 0, 0, 0);
      step(1, 4'b1111, 0, 0, 0);
      step(1, 4'b1111, 0, 1, 0);
      step(1, 4'b1111, 0, 0, 0);
      chk("t2_gap_grant", bus.grant_out, 4'b0000);
      chk("t2_gap_state", bus.arb_state, 0);
    end

    // 3: master 1 never begins; stray end ignored; master 3 pending
    step(1, 4'b1000, 0, 0, 0);
    chk("t3_grant", bus.grant_out, 4'b0010);
    for (int j = 1; j <= 16; j++) begin
      step(1, 4'b1000, 0, (j == 5), 0);
      chk("t3_begin_timeout", bus.begin_timeout, (j == 16));
      chk("t3_state_wb", bus.arb_state, 2);
    end
    step(1, 4'b1000, 0, 0, 0);
    chk("t3_valid_dropped", bus.owner_valid, 0);
    chk("t3_pulse_once", bus.begin_timeout, 0);
    step(1, 4'b0000, 0, 0, 0);
    chk("t3_next_grant", bus.grant_out, 4'b1000);
    chk("t3_next_owner", bus.owner_idx, 3);

    // 4: bus error does not release; stray begin in WAIT_END ignored
    step(1, 4'b0001, 1, 0, 0);
    step(1, 4'b0001, 0, 0, 0);
    chk("t4_state_we", bus.arb_state, 3);
    step(1, 4'b0001, 1, 0, 1);
    chk("t4_err_valid", bus.owner_valid, 1);
    chk("t4_err_grant", bus.grant_out, 4'b0000);
    step(1, 4'b0001, 0, 0, 1);
    step(1, 4'b0001, 0, 0, 0);
    chk("t4_hold_state", bus.arb_state, 3);
    chk("t4_hold_grant", bus.grant_out, 4'b0000);
    step(1, 4'b0001, 0, 1, 0);
    step(1, 4'b0001, 0, 0, 0);
    chk("t4_idle", bus.arb_state, 0);
    step(1, 4'b1000, 0, 0, 0);
    chk("t4_resume_grant", bus.grant_out, 4'b0001);

    // Single-cycle transaction (begin and end together), then master 3 owns the bus
    step(1, 4'b1000, 1, 1, 0);
    chk("t4_single_wb", bus.arb_state, 2);
    step(1, 4'b1000, 0, 0, 0);
    chk("t4_single_idle", bus.arb_state, 0);
    step(1, 4'b0000, 0, 0, 0);
    chk("t6_grant3", bus.grant_out, 4'b1000);
    step(1, 4'b0000, 1, 0, 0);
    step(1, 4'b1001, 0, 0, 0);
    chk("t6_pre_state", bus.arb_state, 3);
    chk("t6_pre_owner", bus.owner_idx, 3);

    // 6: reset mid-transaction
    step(0, 4'b1001, 0, 0, 0);
    step(1, 4'b1001, 0, 0, 0);
    chk("t6_rst_grant", bus.grant_out, 4'b0000);
    chk("t6_rst_owner", bus.owner_idx, 0);
    chk("t6_rst_valid", bus.owner_valid, 0);
    chk("t6_rst_state", bus.arb_state, 0);
    chk("t6_rst_bto", bus.begin_timeout, 0);
    chk("t6_rst_wdt", bus.bus_timeout, 0);
    step(1, 4'b0000, 0, 0, 0);
    chk("t6_grant0", bus.grant_out, 4'b0001);

    // 5: transaction that never ends
    step(1, 4'b0000, 1, 0, 0);
`ifdef BUS_ARB_TIMEOUT_EN
    for (int j = 0; j < 1024; j++) begin
      step(1, 4'b0000, 0, 0, 0);
      chk("t5_wdt_pulse", bus.bus_timeout, (j == 1023));
    end
    step(1, 4'b0000, 0, 0, 0);
    chk("t5_wdt_idle", bus.arb_state, 0);
    chk("t5_wdt_valid", bus.owner_valid, 0);
`else
    for (int j = 0; j < 5000; j++) begin
      step(1, 4'b0000, 0, 0, 0);
      chk("t5_no_wdt", bus.bus_timeout, 0);
    end
    chk("t5_still_we", bus.arb_state, 3);
    chk("t5_still_valid", bus.owner_valid, 1);
`endif
    step(1, 4'b0000, 0, 1, 0);
    step(1, 4'b0000, 0, 0, 0);
    chk("t5_final_idle", bus.arb_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bus_arbiter_rr
`default_nettype wire
